// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register link: frame layout, register map
// addresses and the controller state encoding. Imported by the controller
// and by the peripheral side so both agree on field positions and addresses.
package spi_reg_pkg;

  localparam int FRAME_W  = 16;
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // Register map of the peripheral
  localparam logic [6:0] REG_OUT_7_0  = 7'h00;
  localparam logic [6:0] REG_OUT_15_8 = 7'h01;
  localparam logic [6:0] REG_PWM_7_0  = 7'h02;
  localparam logic [6:0] REG_PWM_15_8 = 7'h03;
  localparam logic [6:0] REG_DUTY     = 7'h04;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    GAP
  } spi_state_t;

  // Assemble an on-wire frame, MSB transmitted first.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic       write,
                                                    input logic [6:0] addr,
                                                    input logic [7:0] data);
    logic [FRAME_W-1:0] f;
    f                    = '0;
    f[RW_BIT]            = write;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[DATA_MSB:DATA_LSB] = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI serial clock.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   restart    : reload the count to 0 (asserted on every state change)
//   tick       : high during the last cycle of each CLK_DIV-cycle phase
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_reg_controller.sv
// SPI initiator (mode 0, MSB first) that turns one register-write command
// per valid/ready handshake into a 16-bit frame {R/W, addr[6:0], data[7:0]}.
// Ports:
//   clk, rst_n                    : system clock, asynchronous active-low reset
//   req_valid/req_ready           : command handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata: command fields, latched at accept
//   SCLK, COPI, nCS               : registered serial link outputs
//   busy                          : frame in progress (accept until ready)
//   done                          : one-cycle pulse as nCS rises after a frame
module spi_reg_controller
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS,
  output logic       busy,
  output logic       done
);

  // The peripheral synchroniser needs each SCLK level for at least 2 clocks.
  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_reg_controller: CLK_DIV must be in 2..255");
  end
  if (GAP_CYC < 1 || GAP_CYC > 255) begin : g_bad_gap_cyc
    $error("spi_reg_controller: GAP_CYC must be in 1..255");
  end

  spi_state_t          state, state_next;
  logic [FRAME_W-1:0]  frame_in;
  logic [FRAME_W-2:0]  shreg;     // bits still to be sent after the one on COPI
  logic [3:0]          bit_cnt;   // index of the bit currently on COPI
  logic [7:0]          gap_cnt;
  logic                tick;
  logic                restart;
  logic                accept;
  logic                gap_end;

  assign frame_in  = pack_frame(req_write, req_addr, req_wdata);
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign gap_end   = (gap_cnt == 8'(GAP_CYC - 1));
  // Keep the divider parked in IDLE so SETUP always starts from count 0.
  assign restart   = (state_next != state) || (state == IDLE);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = SETUP;
      SETUP:   if (tick)      state_next = HIGH;
      HIGH:    if (tick)      state_next = LOW;
      LOW:     if (tick)      state_next = (bit_cnt == 4'd0) ? GAP : HIGH;
      GAP:     if (gap_end)   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Link outputs are registered from the next state so every pin changes
  // exactly at a clock edge, together with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      SCLK    <= 1'b0;
      COPI    <= 1'b0;
      nCS     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      SCLK <= (state_next == HIGH);
      nCS  <= (state_next == IDLE) || (state_next == GAP);
      busy <= (state_next != IDLE);
      done <= (state == LOW) && (state_next == GAP);
      case (state)
        IDLE: begin
          if (accept) begin
            COPI    <= frame_in[RW_BIT];
            shreg   <= frame_in[RW_BIT-1:0];
            bit_cnt <= 4'd15;
          end
        end
        HIGH: begin
          // Falling edge: present the next bit, or drive 0 after bit 0.
          if (tick) begin
            COPI  <= (bit_cnt == 4'd0) ? 1'b0 : shreg[FRAME_W-2];
            shreg <= {shreg[FRAME_W-3:0], 1'b0};
          end
        end
        LOW: begin
          gap_cnt <= '0;
          if (tick && bit_cnt != 4'd0) begin
            bit_cnt <= bit_cnt - 4'd1;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
